// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// and helpers that decode store lanes and request legality.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    function automatic logic [3:0] lsu_wstrb(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (funct3)
            F3_B:    strb = 4'b0001 << addr_lo;
            F3_H:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] data;
        case (funct3)
            F3_B:    data = {4{wdata[7:0]}};
            F3_H:    data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

    // True when the request must be trapped: unknown encoding, unsigned store, or misaligned.
    function automatic logic lsu_req_bad(input logic we, input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr_lo[0];
            F3_W:    bad = (addr_lo != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it for writeback.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   data = {24'd0, byte_v};
            F3_H:    data = {{16{half_v[15]}}, half_v};
            F3_HU:   data = {16'd0, half_v};
            F3_W:    data = rdata;
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rv32i memory-access stage: issues one valid/ready data-memory transaction
// per request and returns aligned, extended load data or an error.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // Abort fires in the last allowed cycle, so mem_valid is high exactly TIMEOUT_CYCLES cycles.
    localparam logic [CNT_W-1:0] CNT_LIMIT = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    lsu_state_e  state_q, state_d;
    logic        mem_valid_q, mem_valid_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] load_data;

    lsu_load_align u_load_align (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .rdata   (mem_rdata),
        .data    (load_data)
    );

    always_comb begin
        state_d      = state_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    funct3_d  = req_funct3;
                    addr_lo_d = req_addr[1:0];
                    cnt_d     = '0;
                    if (lsu_req_bad(req_we, req_funct3, req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else begin
                        state_d     = ST_BUS;
                        mem_valid_d = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wstrb_d = req_we ? lsu_wstrb(req_funct3, req_addr[1:0]) : 4'b0000;
                        mem_wdata_d = req_we ? lsu_wdata(req_funct3, req_wdata) : 32'd0;
                    end
                end
            end
            ST_BUS: begin
                if (mem_ready) begin
                    state_d      = ST_RESP;
                    mem_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = mem_we_q ? 32'd0 : load_data;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LIMIT)) begin
                    state_d      = ST_RESP;
                    mem_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wstrb_q  <= 4'b0000;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            cnt_q        <= '0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign mem_valid  = mem_valid_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a short bus timeout.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int vectors;
    int miscompares;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic issueRequest(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        tick();
        req_valid  = 1'b0;
    endtask

    // Full bus transaction: mem_ready is raised after 'waits' idle bus cycles.
    task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int waits,
                                 input logic [31:0] exp_addr, input logic [3:0] exp_wstrb,
                                 input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        issueRequest(we, f3, addr, wdata);
        checkOutput({tag, ".mem_valid"}, {31'd0, mem_valid}, 32'd1);
        checkOutput({tag, ".req_ready"}, {31'd0, req_ready}, 32'd0);
        checkOutput({tag, ".mem_we"},    {31'd0, mem_we},    {31'd0, we});
        checkOutput({tag, ".mem_addr"},  mem_addr,           exp_addr);
        checkOutput({tag, ".mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
        checkOutput({tag, ".mem_wdata"}, mem_wdata,          exp_wdata);
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            tick();
            checkOutput({tag, ".hold_valid"}, {31'd0, mem_valid}, 32'd1);
            checkOutput({tag, ".hold_addr"},  mem_addr,           exp_addr);
            checkOutput({tag, ".hold_resp"},  {31'd0, resp_valid}, 32'd0);
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        checkOutput({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
        checkOutput({tag, ".resp_err"},   {31'd0, resp_err},   32'd0);
        checkOutput({tag, ".resp_rdata"}, resp_rdata,          exp_rdata);
        checkOutput({tag, ".mem_drop"},   {31'd0, mem_valid},  32'd0);
        tick();
        checkOutput({tag, ".resp_pulse"}, {31'd0, resp_valid}, 32'd0);
        checkOutput({tag, ".ready_back"}, {31'd0, req_ready},  32'd1);
        checkOutput({tag, ".rdata_hold"}, resp_rdata,          exp_rdata);
    endtask

    task automatic applyErrorRequest(input string tag, input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr);
        issueRequest(we, f3, addr, 32'hFFFF_FFFF);
        checkOutput({tag, ".mem_valid"},  {31'd0, mem_valid},  32'd0);
        checkOutput({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
        checkOutput({tag, ".resp_err"},   {31'd0, resp_err},   32'd1);
        checkOutput({tag, ".resp_rdata"}, resp_rdata,          32'd0);
        tick();
        checkOutput({tag, ".mem_valid2"}, {31'd0, mem_valid},  32'd0);
        checkOutput({tag, ".resp_pulse"}, {31'd0, resp_valid}, 32'd0);
        checkOutput({tag, ".ready_back"}, {31'd0, req_ready},  32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_funct3  = 3'b000;
        req_addr    = 32'd0;
        req_wdata   = 32'd0;
        mem_ready   = 1'b0;
        mem_rdata   = 32'd0;

        tick();
        checkOutput("rst.req_ready",  {31'd0, req_ready},  32'd1);
        checkOutput("rst.mem_valid",  {31'd0, mem_valid},  32'd0);
        checkOutput("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst.resp_rdata", resp_rdata,          32'd0);
        checkOutput("rst.resp_err",   {31'd0, resp_err},   32'd0);
        checkOutput("rst.mem_addr",   mem_addr,            32'd0);
        checkOutput("rst.mem_wstrb",  {28'd0, mem_wstrb},  32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] stores and loads");
        applyStimulus("sw",  1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 2,
                      32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        applyStimulus("lb",  1'b0, 3'b000, 32'h0000_0200, 32'h0, 32'h8001_7FF4, 0,
                      32'h0000_0200, 4'b0000, 32'h0, 32'hFFFF_FFF4);
        applyStimulus("lbu", 1'b0, 3'b100, 32'h0000_0200, 32'h0, 32'h8001_7FF4, 0,
                      32'h0000_0200, 4'b0000, 32'h0, 32'h0000_00F4);
        applyStimulus("lb1", 1'b0, 3'b000, 32'h0000_0201, 32'h0, 32'h8001_7FF4, 1,
                      32'h0000_0200, 4'b0000, 32'h0, 32'h0000_007F);
        applyStimulus("lbu3", 1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h8001_7FF4, 0,
                      32'h0000_0200, 4'b0000, 32'h0, 32'h0000_0080);
        applyStimulus("lh",  1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_7FF4, 0,
                      32'h0000_0200, 4'b0000, 32'h0, 32'hFFFF_8001);
        applyStimulus("lhu", 1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h8001_7FF4, 0,
                      32'h0000_0200, 4'b0000, 32'h0, 32'h0000_8001);
        applyStimulus("lh0", 1'b0, 3'b001, 32'h0000_0200, 32'h0, 32'h8001_7FF4, 0,
                      32'h0000_0200, 4'b0000, 32'h0, 32'h0000_7FF4);
        applyStimulus("lw",  1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h8001_7FF4, 0,
                      32'h0000_0200, 4'b0000, 32'h0, 32'h8001_7FF4);
        applyStimulus("sb",  1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h5555_5555, 0,
                      32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        applyStimulus("sb1", 1'b1, 3'b000, 32'h0000_0101, 32'h0000_0037, 32'h0, 0,
                      32'h0000_0100, 4'b0010, 32'h3737_3737, 32'h0);
        applyStimulus("sh",  1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0, 1,
                      32'h0000_0100, 4'b1100, 32'h1234_1234, 32'h0);
        applyStimulus("sh0", 1'b1, 3'b001, 32'h0000_0100, 32'h0000_ABCD, 32'h0, 0,
                      32'h0000_0100, 4'b0011, 32'hABCD_ABCD, 32'h0);

        $display("[TB] error requests");
        applyErrorRequest("lw_mis",  1'b0, 3'b010, 32'h0000_0006);
        applyErrorRequest("ld_f011", 1'b0, 3'b011, 32'h0000_0000);
        applyErrorRequest("lh_mis",  1'b0, 3'b001, 32'h0000_0201);
        applyErrorRequest("sw_mis",  1'b1, 3'b010, 32'h0000_0102);
        applyErrorRequest("st_f100", 1'b1, 3'b100, 32'h0000_0100);

        $display("[TB] bus timeout");
        issueRequest(1'b0, 3'b010, 32'h0000_0300, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("to.mem_valid",  {31'd0, mem_valid},  32'd1);
            checkOutput("to.resp_valid", {31'd0, resp_valid}, 32'd0);
            tick();
        end
        checkOutput("to.mem_drop",   {31'd0, mem_valid},  32'd0);
        checkOutput("to.resp_valid", {31'd0, resp_valid}, 32'd1);
        checkOutput("to.resp_err",   {31'd0, resp_err},   32'd1);
        checkOutput("to.resp_rdata", resp_rdata,          32'd0);
        tick();
        checkOutput("to.ready_back", {31'd0, req_ready},  32'd1);

        applyStimulus("to_ready4", 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h1234_5678, 3,
                      32'h0000_0300, 4'b0000, 32'h0, 32'h1234_5678);

        $display("[TB] reset during bus phase");
        issueRequest(1'b0, 3'b010, 32'h0000_0400, 32'h0);
        checkOutput("rstmid.mem_valid_pre", {31'd0, mem_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid.mem_valid", {31'd0, mem_valid},  32'd0);
        checkOutput("rstmid.req_ready", {31'd0, req_ready},  32'd1);
        checkOutput("rstmid.rdata_clr", resp_rdata,          32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("rstmid.no_resp",   {31'd0, resp_valid}, 32'd0);
        checkOutput("rstmid.mem_idle",  {31'd0, mem_valid},  32'd0);
        tick();
        checkOutput("rstmid.no_resp2",  {31'd0, resp_valid}, 32'd0);
        applyStimulus("after_rst", 1'b0, 3'b010, 32'h0000_0404, 32'h0, 32'hCAFE_F00D, 0,
                      32'h0000_0404, 4'b0000, 32'h0, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU in the rv32i datapath. It takes the ALU result as the effective address, plus rs2 data and funct3. It issues one data-memory transaction over a valid/ready bus and returns load data aligned and sign- or zero-extended for writeback. Misaligned accesses, illegal funct3 encodings and bus timeouts are reported as errors so the core can trap.

Parameters:
TIMEOUT_CYCLES, 255, maximum number of cycles mem_valid may wait for mem_ready; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  core presents an access request
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  32  effective address (ALU res)
req_wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal funct3 or timeout; qualified by resp_valid
mem_valid  out  1  bus request
mem_ready  in  1  bus completion; mem_rdata is valid in the same cycle
mem_we  out  1  bus write enable
mem_addr  out  32  word address {req_addr[31:2],2'b00}
mem_wstrb  out  4  byte enables; 0000 for loads
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read word

Behaviour:
- Reset (asynchronous, active-low): state IDLE. Registered outputs go to 0: mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata, resp_valid, resp_rdata, resp_err, timeout counter. req_ready = (state==IDLE), so it reads 1 during reset.
- FSM states: IDLE, BUS, RESP.
- IDLE: a request is accepted when req_valid && req_ready; all request fields are captured at that edge.
  - If the request is illegal or misaligned: go to RESP with err=1. mem_valid is never asserted.
  - Otherwise: go to BUS. mem_valid and the mem_* fields are registered, so they are visible in the cycle after acceptance.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other encoding is illegal.
- Misaligned:
  - Halfword (LH/LHU/SH) with addr[0]=1.
  - Word (LW/SW) with addr[1:0]!=0.
- Store lanes:
  - SB: wstrb = 0001<<addr[1:0]; wdata = byte replicated ×4.
  - SH: wstrb = 0011 or 1100 by addr[1]; wdata = halfword replicated ×2.
  - SW: wstrb = 1111; wdata = rs2.
- BUS: mem_* fields are held stable while mem_valid is high.
  - On mem_ready: drop mem_valid, capture the extracted load data (0 for stores), go to RESP with err=0.
  - Timeout counter increments each BUS cycle without mem_ready. If TIMEOUT_CYCLES>0 and mem_valid has been high for TIMEOUT_CYCLES cycles without mem_ready: drop mem_valid, go to RESP with err=1, rdata=0. This abort is the defined bus-side rule.
  - If mem_ready arrives in the same cycle as the timeout limit, mem_ready wins.
- Load extraction: byte lane = addr[1:0]; halfword = addr[1] ? rdata[31:16] : rdata[15:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_err hold their value until the next response and are cleared only by reset. There is no consumer backpressure.
- Latency:
  - Zero-wait-state memory (mem_ready high the first cycle mem_valid is high): accept at cycle 0, mem_valid in cycle 1, resp_valid in cycle 2, req_ready again in cycle 3.
  - Error detected at acceptance: resp_valid in cycle 1.
- Reset mid-transaction: mem_valid drops asynchronously, no resp_valid is produced, the transaction is lost.
- The timeout counter is sized $clog2(TIMEOUT_CYCLES+1), with a minimum of 1 bit.

Decomposition:
- Package lsu_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state enum, and a function returning wstrb from funct3/addr[1:0].
- Sub-module lsu_load_align: combinational; inputs funct3, addr[1:0], mem_rdata; output 32-bit extended data.

Test Plan:
- SW addr 0x00000100, wdata 0xDEADBEEF, mem_ready 2 cycles after mem_valid -> mem_addr 0x100, wstrb 1111, wdata 0xDEADBEEF, mem_we 1; resp_valid pulse with err 0, rdata 0.
- SB addr 0x103, wdata 0x000000A5; SH addr 0x102, wdata 0x00001234 -> wstrb 1000 with wdata 0xA5A5A5A5; wstrb 1100 with wdata 0x12341234; mem_addr 0x100 for both.
- mem_rdata 0x80017FF4 -> results:
  - LB @0x200 -> 0xFFFFFFF4; LBU @0x200 -> 0x000000F4.
  - LH @0x202 -> 0xFFFF8001; LHU @0x202 -> 0x00008001.
  - LW @0x200 -> 0x80017FF4.
- LW addr 0x006, then load funct3 011 -> mem_valid never rises; resp_valid in the cycle after acceptance with err 1, rdata 0.
- TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_valid high exactly 4 cycles, then resp_valid with err 1. Repeat with mem_ready in the 4th cycle -> err 0.
- rst_n low while in BUS -> mem_valid 0 immediately, no resp_valid; after release req_ready 1 and the next LW completes normally.
